// File: rtl/ysyx_22040175_sram_resp_if.sv
// Fetch and data request/response bundle between a CPU core and the SRAM responder.
interface ysyx_22040175_sram_resp_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        if_resp_err;

  logic        d_req_valid;
  logic        d_req_wen;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic [7:0]  d_req_wmask;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;
  logic        d_resp_err;

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
    output d_req_valid, d_req_wen, d_req_addr, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
    input  d_req_valid, d_req_wen, d_req_addr, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err
  );
endinterface

// File: rtl/ysyx_22040175_sram_resp.sv
// Single-ported 64-bit SRAM serving one fetch or data request at a time with a
// fixed LAT-cycle response. Optional macro SRAM_RESP_BOUNDS_CHK_EN flags
// addresses beyond the array as errors instead of wrapping them.
module ysyx_22040175_sram_resp #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LAT        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22040175_sram_resp_if.slave bus
);
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {BOOT, IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, owner_d;        // 1 = data port owns the transaction
  logic                  ready_q, ready_d;
  logic [63:0]           pend_data_q, pend_data_d;
  logic                  pend_err_q, pend_err_d;
  logic                  if_valid_q, if_valid_d;
  logic                  if_err_q, if_err_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic                  d_valid_q, d_valid_d;
  logic                  d_err_q, d_err_d;
  logic [63:0]           d_rdata_q, d_rdata_d;

  logic [63:0]           mem [WORDS];
  logic                  d_acc, i_acc;
  logic [31:0]           acc_addr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [63:0]           rd_word;
  logic                  oob, misalign, we;

  // Request arbitration: the data port wins whenever it is valid.
  assign d_acc    = ready_q && bus.d_req_valid;
  assign i_acc    = ready_q && !bus.d_req_valid && bus.if_req_valid;
  assign acc_addr = bus.d_req_valid ? bus.d_req_addr : bus.if_req_addr;
  assign idx      = acc_addr[DEPTH_LOG2+2:3];
  assign rd_word  = mem[idx];
  assign misalign = (acc_addr[1:0] != 2'b00);

`ifdef SRAM_RESP_BOUNDS_CHK_EN
  assign oob = ((acc_addr >> (DEPTH_LOG2 + 3)) != 32'd0);
`else
  logic unused_hi_addr;
  assign unused_hi_addr = ^acc_addr[31:DEPTH_LOG2+3];
  assign oob            = 1'b0;
`endif

  assign we = d_acc && bus.d_req_wen && !oob;

  // Masked store at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.d_req_wmask[b]) mem[idx][8*b +: 8] <= bus.d_req_wdata[8*b +: 8];
      end
    end
  end

  // Next-state and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    if_valid_d  = 1'b0;
    if_err_d    = if_err_q;
    if_inst_d   = if_inst_q;
    d_valid_d   = 1'b0;
    d_err_d     = d_err_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      BOOT: state_d = IDLE;
      IDLE: begin
        if (d_acc || i_acc) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LAT - 1);
          owner_d = d_acc;
          if (d_acc) begin
            pend_err_d  = oob;
            pend_data_d = (bus.d_req_wen || oob) ? 64'd0 : rd_word;
          end else begin
            pend_err_d  = oob || misalign;
            pend_data_d = (oob || misalign) ? 64'd0 :
                          {32'd0, acc_addr[2] ? rd_word[63:32] : rd_word[31:0]};
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q) begin
            d_valid_d = 1'b1;
            d_err_d   = pend_err_q;
            d_rdata_d = pend_data_q;
          end else begin
            if_valid_d = 1'b1;
            if_err_d   = pend_err_q;
            if_inst_d  = pend_data_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = BOOT;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      ready_q     <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_inst_q   <= '0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      ready_q     <= ready_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      if_inst_q   <= if_inst_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // The fetch ready is masked by a live data request so a fetch is never
  // shown as accepted in a cycle the data port takes.
  assign bus.if_req_ready  = ready_q && !bus.d_req_valid;
  assign bus.d_req_ready   = ready_q;
  assign bus.if_resp_valid = if_valid_q;
  assign bus.if_resp_inst  = if_inst_q;
  assign bus.if_resp_err   = if_err_q;
  assign bus.d_resp_valid  = d_valid_q;
  assign bus.d_resp_rdata  = d_rdata_q;
  assign bus.d_resp_err    = d_err_q;
endmodule
